// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter.
//   state_t           : arbiter FSM states
//   RD_CODE_W/WR_CODE_W: widths of the memory read/write command codes
//   IMEM_RD_CODE_DFLT : read code used for instruction fetches ({enable, funct3=LW})
//   MEM_RD_IDLE/MEM_WR_IDLE: "no operation" command codes
package mem_arb_pkg;

  localparam int unsigned RD_CODE_W = 4;
  localparam int unsigned WR_CODE_W = 3;

  localparam logic [RD_CODE_W-1:0] IMEM_RD_CODE_DFLT = 4'b1010;
  localparam logic [RD_CODE_W-1:0] MEM_RD_IDLE       = '0;
  localparam logic [WR_CODE_W-1:0] MEM_WR_IDLE       = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StInst = 2'd2,
    StDone = 2'd3
  } state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one backing memory port between instruction fetch and data access.
// Per pipeline advance it performs at most one data access followed by one
// fetch, stalling the whole pipeline through the single busywait output.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   imem_read/addr     : fetch request and PC; imem_inst returns the held instruction
//   dmem_read/write    : data read/write codes (nonzero = request), dmem_addr, dmem_wdata
//   dmem_rdata         : held load data
//   busywait           : global pipeline stall
//   mem_*              : registered command/address/data to the backing memory,
//                        mem_rdata and mem_busywait come back from it
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned           ADDR_W       = 32,
  parameter int unsigned           DATA_W       = 32,
  parameter logic [RD_CODE_W-1:0]  IMEM_RD_CODE = IMEM_RD_CODE_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_read,
  input  logic [ADDR_W-1:0]    imem_addr,
  output logic [DATA_W-1:0]    imem_inst,
  input  logic [RD_CODE_W-1:0] dmem_read,
  input  logic [WR_CODE_W-1:0] dmem_write,
  input  logic [ADDR_W-1:0]    dmem_addr,
  input  logic [DATA_W-1:0]    dmem_wdata,
  output logic [DATA_W-1:0]    dmem_rdata,
  output logic                 busywait,
  output logic [RD_CODE_W-1:0] mem_read,
  output logic [WR_CODE_W-1:0] mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_busywait
);

  state_t              state_q;
  logic                issued_q;
  logic                imem_read_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic                data_rd_q;

  logic data_req;
  logic any_req;

  assign data_req = (dmem_read != MEM_RD_IDLE) | (dmem_write != MEM_WR_IDLE);
  assign any_req  = imem_read | data_req;

  // Stall is raised combinationally in IDLE so the request is held until DONE.
  assign busywait = ((state_q == StIdle) & any_req) | (state_q == StData) |
                    (state_q == StInst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      issued_q    <= 1'b0;
      imem_read_q <= 1'b0;
      imem_addr_q <= '0;
      data_rd_q   <= 1'b0;
      imem_inst   <= '0;
      dmem_rdata  <= '0;
      mem_read    <= MEM_RD_IDLE;
      mem_write   <= MEM_WR_IDLE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            imem_read_q <= imem_read;
            imem_addr_q <= imem_addr;
            issued_q    <= 1'b0;
            if (data_req) begin
              state_q   <= StData;
              mem_addr  <= dmem_addr;
              mem_wdata <= dmem_wdata;
              mem_write <= dmem_write;
              // A store takes priority; a simultaneous load is dropped.
              mem_read  <= (dmem_write != MEM_WR_IDLE) ? MEM_RD_IDLE : dmem_read;
              data_rd_q <= (dmem_write == MEM_WR_IDLE);
            end else begin
              state_q   <= StInst;
              mem_addr  <= imem_addr;
              mem_read  <= IMEM_RD_CODE;
              mem_write <= MEM_WR_IDLE;
            end
          end
        end

        StData: begin
          // The first cycle only issues; completion needs a later idle memory.
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (!mem_busywait) begin
            issued_q <= 1'b0;
            if (data_rd_q) begin
              dmem_rdata <= mem_rdata;
            end
            if (imem_read_q) begin
              state_q   <= StInst;
              mem_addr  <= imem_addr_q;
              mem_read  <= IMEM_RD_CODE;
              mem_write <= MEM_WR_IDLE;
            end else begin
              state_q   <= StDone;
              mem_read  <= MEM_RD_IDLE;
              mem_write <= MEM_WR_IDLE;
            end
          end
        end

        StInst: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (!mem_busywait) begin
            issued_q  <= 1'b0;
            imem_inst <= mem_rdata;
            state_q   <= StDone;
            mem_read  <= MEM_RD_IDLE;
            mem_write <= MEM_WR_IDLE;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [3:0]  dmem_read;
  logic [2:0]  dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        busywait;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busywait;

  int checks;
  int failures;

  // Reference model: values the CPU should currently see on the held outputs.
  logic [31:0] exp_inst;
  logic [31:0] exp_drdata;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .IMEM_RD_CODE (4'b1010)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_addr    (imem_addr),
    .imem_inst    (imem_inst),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic drive_idle_inputs();
    imem_read  = 1'b0;
    imem_addr  = '0;
    dmem_read  = '0;
    dmem_write = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
  endtask

  // One pipeline advance, modelled as a timeline:
  //   1 request cycle, (2 + data waits) data cycles if any data request,
  //   (2 + fetch waits) fetch cycles if a fetch, then 1 done cycle.
  // The bench plays the memory: busy for exactly `w` cycles after the issue
  // cycle, and read data is valid only on the completing cycle.
  task automatic run_txn(input string name, input logic ir, input logic [3:0] dr,
                         input logic [2:0] dw, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] drd, input logic [31:0] ird,
                         input int wdw, input int wiw, input bit scramble);
    bit is_data;
    bit is_wr;
    int nd;
    int ni;
    int total;
    is_data = (dr != 0) || (dw != 0);
    is_wr   = (dw != 0);
    nd      = is_data ? wdw + 2 : 0;
    ni      = ir ? wiw + 2 : 0;
    total   = nd + ni + 2;
    for (int c = 0; c < total; c++) begin
      int          ph;  // 0 request, 1 data, 2 fetch, 3 done
      int          k;
      int          w;
      logic        eb;
      logic [3:0]  er;
      logic [2:0]  ew;
      logic [31:0] ea;
      k = 0;
      if (c == 0) ph = 0;
      else if (c <= nd) begin ph = 1; k = c - 1; end
      else if (c <= nd + ni) begin ph = 2; k = c - 1 - nd; end
      else ph = 3;
      w = (ph == 1) ? wdw : wiw;

      @(negedge clk);
      if (ph == 0) begin
        imem_read  = ir;
        imem_addr  = ia;
        dmem_read  = dr;
        dmem_write = dw;
        dmem_addr  = da;
        dmem_wdata = wd;
      end else if (scramble && (ph == 1 || ph == 2)) begin
        imem_addr  = $urandom;
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
      end
      if (ph == 1 || ph == 2) begin
        mem_busywait = (k == 0) ? 1'($urandom % 2) : (k <= w);
      end else begin
        mem_busywait = 1'($urandom % 2);
      end
      if (ph == 1 && k == wdw + 1) mem_rdata = drd;
      else if (ph == 2 && k == wiw + 1) mem_rdata = ird;
      else mem_rdata = $urandom;

      if (ph == 3) begin
        if (is_data && !is_wr) exp_drdata = drd;
        if (ir) exp_inst = ird;
      end

      eb = (ph != 3);
      er = 4'b0;
      ew = 3'b0;
      ea = ir ? ia : da;
      if (ph == 1) begin
        ew = dw;
        er = is_wr ? 4'b0 : dr;
        ea = da;
      end else if (ph == 2) begin
        er = 4'b1010;
        ea = ia;
      end
      #1;
      checks++;
      if ({busywait, mem_read, mem_write} !== {eb, er, ew}) begin
        failures++;
        $display("FAIL %s cyc%0d busy/rd/wr: got %b/%b/%b exp %b/%b/%b", name, c,
                 busywait, mem_read, mem_write, eb, er, ew);
      end
      if (ph != 0) begin
        checks++;
        if (mem_addr !== ea) begin
          failures++;
          $display("FAIL %s cyc%0d mem_addr: got %h exp %h", name, c, mem_addr, ea);
        end
      end
      if (ph == 1 && is_wr) begin
        checks++;
        if (mem_wdata !== wd) begin
          failures++;
          $display("FAIL %s cyc%0d mem_wdata: got %h exp %h", name, c, mem_wdata, wd);
        end
      end
      if (ph == 3) begin
        checks++;
        if ({imem_inst, dmem_rdata} !== {exp_inst, exp_drdata}) begin
          failures++;
          $display("FAIL %s done inst/drdata: got %h/%h exp %h/%h", name, imem_inst,
                   dmem_rdata, exp_inst, exp_drdata);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({busywait, mem_read, mem_write, mem_addr, mem_wdata, imem_inst, dmem_rdata} !==
        {1'b0, 4'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL %s: got busy=%b rd=%b wr=%b addr=%h wdata=%h inst=%h drdata=%h exp all 0",
               name, busywait, mem_read, mem_write, mem_addr, mem_wdata, imem_inst, dmem_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle_inputs();
    mem_rdata    = '0;
    mem_busywait = 1'b0;
    exp_inst     = '0;
    exp_drdata   = '0;
    #2;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_no_req();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle_inputs();
      mem_busywait = 1'($urandom % 2);
      #1;
      checks++;
      if ({busywait, mem_read, mem_write} !== 8'b0) begin
        failures++;
        $display("FAIL idle_no_req cyc%0d busy/rd/wr: got %b/%b/%b exp 0/0000/000", i,
                 busywait, mem_read, mem_write);
      end
    end
  endtask

  task automatic test_fetch_only();
    run_txn("fetch_only", 1'b1, 4'b0, 3'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0050_0093,
            0, 0, 1'b0);
  endtask

  task automatic test_load_fetch();
    run_txn("load_fetch", 1'b1, 4'b1010, 3'b0, 32'h14, 32'h100, 32'h0, 32'hDEAD_BEEF,
            32'h0000_0013, 0, 0, 1'b0);
  endtask

  task automatic test_store_slow();
    run_txn("store_slow", 1'b0, 4'b0, 3'b010, 32'h0, 32'h200, 32'h1234_5678, 32'h0, 32'h0,
            3, 0, 1'b0);
  endtask

  task automatic test_conflict();
    run_txn("conflict", 1'b1, 4'b1010, 3'b010, 32'h18, 32'h300, 32'hCAFE_F00D, 32'h0,
            32'h0000_0033, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b1, 4'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1111_0001,
            0, 1, 1'b1);
    run_txn("b2b_second", 1'b1, 4'b0, 3'b0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h2222_0002,
            2, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic       ir;
      logic [3:0] dr;
      logic [2:0] dw;
      int         kind;
      ir   = 1'($urandom % 2);
      kind = $urandom_range(0, 3);  // 0 none, 1 load, 2 store, 3 load+store
      dr   = (kind == 1 || kind == 3) ? {1'b1, 3'($urandom)} : 4'b0;
      dw   = (kind >= 2) ? 3'($urandom_range(1, 7)) : 3'b0;
      if (!ir && kind == 0) ir = 1'b1;
      run_txn("random", ir, dr, dw, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom % 2));
      if ($urandom_range(0, 3) == 0) test_idle_no_req();
    end
  endtask

  task automatic test_reset_mid_access();
    run_txn("pre_reset", 1'b1, 4'b1010, 3'b0, 32'h40, 32'h44, 32'h0, 32'hA5A5_0001,
            32'h5A5A_0002, 0, 0, 1'b0);
    @(negedge clk);
    dmem_read    = 4'b1010;
    dmem_addr    = 32'h300;
    imem_read    = 1'b0;
    mem_busywait = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mem_read !== 4'b1010) begin
      failures++;
      $display("FAIL reset_mid precondition mem_read: got %b exp 1010", mem_read);
    end
    #1;
    rst = 1'b0;
    drive_idle_inputs();
    exp_inst   = '0;
    exp_drdata = '0;
    #1;
    check_reset_outputs("reset_mid_access");
    @(negedge clk);
    rst          = 1'b1;
    mem_busywait = 1'b0;
    run_txn("post_reset_fetch", 1'b1, 4'b0, 3'b0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0000_0073,
            0, 0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_idle_no_req();
    test_fetch_only();
    test_load_fetch();
    test_store_slow();
    test_conflict();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
